// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver with majority voting,
// configurable width/parity/stop bits and a held output word.
module uart_rx_param #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 RxD,
  input  logic                 baud_tick,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 RDA,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = 4;
  localparam logic [SW-1:0] C_LO  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] C_MID = SW'(OVERSAMPLE/2);
  localparam logic [SW-1:0] C_HI  = SW'(OVERSAMPLE/2 + 1);
  localparam logic [SW-1:0] C_END = SW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PAR, S_STOP
  } state_t;

  state_t                 state;
  state_t                 state_n;
  logic                   sync1;
  logic                   rxs;
  logic [SW-1:0]          scnt;
  logic [BW-1:0]          bcnt;
  logic                   v_lo;
  logic                   v_mid;
  logic [DATA_BITS-1:0]   shreg;
  logic                   pend_frm;
  logic                   pend_par;

  logic tick_lo;
  logic tick_mid;
  logic decide;
  logic wrap;
  logic maj;
  logic last_data;
  logic last_stop;
  logic exp_par;
  logic shift_en;
  logic par_bad;
  logic stop_bad;
  logic load;

  // two-flop synchroniser, idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= RxD;
      rxs   <= sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_n;
  end

  // FSM next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!rxs) state_n = S_START;
      S_START: begin
        if (decide && maj) state_n = S_IDLE;
        else if (wrap)     state_n = S_DATA;
      end
      S_DATA: begin
        if (wrap && last_data)
          state_n = (PARITY != 0) ? S_PAR : S_STOP;
      end
      S_PAR:   if (wrap) state_n = S_STOP;
      S_STOP:  if (decide && last_stop) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // FSM output and sample-point decode
  always_comb begin
    tick_lo   = baud_tick && (scnt == C_LO);
    tick_mid  = baud_tick && (scnt == C_MID);
    decide    = baud_tick && (scnt == C_HI);
    wrap      = baud_tick && (scnt == C_END);
    maj       = (v_lo & v_mid) | (v_lo & rxs) | (v_mid & rxs);
    last_data = (bcnt == BW'(DATA_BITS));
    last_stop = (bcnt == BW'(STOP_BITS - 1));
    exp_par   = (PARITY == 1) ? ^shreg : ~^shreg;
    shift_en  = decide && (state == S_DATA);
    par_bad   = decide && (state == S_PAR) && (maj != exp_par);
    stop_bad  = decide && (state == S_STOP) && !maj;
    load      = decide && (state == S_STOP) && last_stop;
  end

  // sample/bit counters, vote capture, shift register, pending flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt     <= '0;
      bcnt     <= '0;
      v_lo     <= 1'b0;
      v_mid    <= 1'b0;
      shreg    <= '0;
      pend_frm <= 1'b0;
      pend_par <= 1'b0;
    end else begin
      if (state == S_IDLE)
        scnt <= '0;
      else if (baud_tick)
        scnt <= (scnt == C_END) ? '0 : scnt + 1'b1;
      if (tick_lo)  v_lo  <= rxs;
      if (tick_mid) v_mid <= rxs;
      if (state_n != state)
        bcnt <= '0;
      else if (decide && (state == S_DATA || state == S_STOP))
        bcnt <= bcnt + 1'b1;
      if (shift_en)
        shreg <= {maj, shreg[DATA_BITS-1:1]};
      if (state == S_IDLE) begin
        pend_frm <= 1'b0;
        pend_par <= 1'b0;
      end else begin
        if (par_bad)  pend_par <= 1'b1;
        if (stop_bad) pend_frm <= 1'b1;
      end
    end
  end

  // registered outputs: frame load wins over a same-cycle ack
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data     <= '0;
      RDA         <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      busy <= (state_n != S_IDLE);
      if (load) begin
        rx_data     <= shreg;
        RDA         <= 1'b1;
        frame_err   <= pend_frm | stop_bad;
        parity_err  <= pend_par;
        overrun_err <= !rd_ack && (overrun_err || RDA);
      end else if (rd_ack && RDA) begin
        RDA         <= 1'b0;
        frame_err   <= 1'b0;
        parity_err  <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: three receiver configurations (8N1, 8E1, 9O2)
// driven by a serial line model; checks vectors and random frames.
module tb_uart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic [1:0] tdiv = 2'd0;
  logic [2:0] rxd = 3'b111;
  logic [2:0] ack = 3'b000;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [8:0] d2;
  logic [2:0] rda;
  logic [2:0] fe;
  logic [2:0] pe;
  logic [2:0] ov;
  logic [2:0] bsy;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int BIT = 64;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    tdiv      <= tdiv + 2'd1;
    baud_tick <= (tdiv == 2'd2);
  end

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(rst_n), .RxD(rxd[0]), .baud_tick(baud_tick),
    .rd_ack(ack[0]), .rx_data(d0), .RDA(rda[0]), .frame_err(fe[0]),
    .parity_err(pe[0]), .overrun_err(ov[0]), .busy(bsy[0]));

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(rst_n), .RxD(rxd[1]), .baud_tick(baud_tick),
    .rd_ack(ack[1]), .rx_data(d1), .RDA(rda[1]), .frame_err(fe[1]),
    .parity_err(pe[1]), .overrun_err(ov[1]), .busy(bsy[1]));

  uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(rst_n), .RxD(rxd[2]), .baud_tick(baud_tick),
    .rd_ack(ack[2]), .rx_data(d2), .RDA(rda[2]), .frame_err(fe[2]),
    .parity_err(pe[2]), .overrun_err(ov[2]), .busy(bsy[2]));

  typedef struct {
    int         sel;
    logic [8:0] data;
    bit         pflip;
    bit         sbad;
    bit         do_ack;
    logic [8:0] exp_data;
    bit         exp_fe;
    bit         exp_pe;
    bit         exp_ov;
  } vec_t;

  vec_t vecs[10];
  bit [2:0] rda_m;
  bit [2:0] ov_m;
  int k_load;

  function automatic logic [8:0] data_of(input int s);
    case (s)
      0:       return {1'b0, d0};
      1:       return {1'b0, d1};
      default: return d2;
    endcase
  endfunction

  function automatic logic odd_ones(input logic [8:0] d, input int nb);
    int c = 0;
    for (int i = 0; i < nb; i++) c += int'(d[i]);
    return (c % 2) == 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bitp(input int s, input logic v, input int n);
    rxd[s] = v;
    repeat (n) @(posedge clk);
  endtask

  task automatic align();
    int t = 0;
    @(negedge clk);
    while (!baud_tick && t < 16) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic send(input int s, input logic [8:0] d, input bit pflip,
                      input bit sbad, input bit glitch);
    int   nb = (s == 2) ? 9 : 8;
    int   ns = (s == 2) ? 2 : 1;
    logic p;
    bitp(s, 1'b0, BIT);
    for (int i = 0; i < nb; i++) begin
      if (glitch && i == 3) begin
        bitp(s, d[i], 32);
        bitp(s, !d[i], 4);
        bitp(s, d[i], 28);
      end else begin
        bitp(s, d[i], BIT);
      end
    end
    if (s != 0) begin
      p = odd_ones(d, nb);
      if (s == 2) p = !p;
      bitp(s, p ^ pflip, BIT);
    end
    for (int j = 0; j < ns; j++)
      bitp(s, !(sbad && j == 0), BIT);
    rxd[s] = 1'b1;
  endtask

  task automatic gap();
    repeat (96) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_frame(input string tag, input int s, input logic [8:0] ed,
                           input bit efe, input bit epe, input bit eov);
    chk({tag, ".data"}, data_of(s), ed);
    chk({tag, ".rda"}, rda[s], 1'b1);
    chk({tag, ".frame_err"}, fe[s], efe);
    chk({tag, ".parity_err"}, pe[s], epe);
    chk({tag, ".overrun_err"}, ov[s], eov);
  endtask

  task automatic do_ack(input string tag, input int s);
    @(negedge clk);
    ack[s] = 1'b1;
    @(negedge clk);
    ack[s] = 1'b0;
    chk({tag, ".ack_rda"}, rda[s], 1'b0);
    chk({tag, ".ack_errs"}, {fe[s], pe[s], ov[s]}, 3'b000);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'h0A5, 0, 0, 1, 9'h0A5, 0, 0, 0};
    vecs[1] = '{1, 9'h03C, 1, 0, 1, 9'h03C, 0, 1, 0};
    vecs[2] = '{1, 9'h03C, 0, 0, 1, 9'h03C, 0, 0, 0};
    vecs[3] = '{0, 9'h055, 0, 1, 1, 9'h055, 1, 0, 0};
    vecs[4] = '{0, 9'h012, 0, 0, 1, 9'h012, 0, 0, 0};
    vecs[5] = '{2, 9'h1AB, 0, 0, 1, 9'h1AB, 0, 0, 0};
    vecs[6] = '{2, 9'h0FF, 1, 1, 1, 9'h0FF, 1, 1, 0};
    vecs[7] = '{0, 9'h000, 0, 0, 0, 9'h000, 0, 0, 0};
    vecs[8] = '{0, 9'h0FF, 0, 0, 1, 9'h0FF, 0, 0, 1};
    vecs[9] = '{1, 9'h081, 0, 1, 1, 9'h081, 1, 0, 0};

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset.data", d0, 8'h00);
    chk("reset.rda", rda[0], 1'b0);
    chk("reset.errs", {fe[0], pe[0], ov[0]}, 3'b000);
    chk("reset.busy", bsy, 3'b000);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);

    for (int v = 0; v < 10; v++) begin
      align();
      send(vecs[v].sel, vecs[v].data, vecs[v].pflip, vecs[v].sbad, 1'b0);
      gap();
      chk_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].exp_data,
                vecs[v].exp_fe, vecs[v].exp_pe, vecs[v].exp_ov);
      if (vecs[v].do_ack) do_ack($sformatf("vec%0d", v), vecs[v].sel);
    end

    align();
    rxd[0] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("false_start.busy_hi", bsy[0], 1'b1);
    repeat (10) @(posedge clk);
    rxd[0] = 1'b1;
    repeat (128) @(posedge clk);
    @(negedge clk);
    chk("false_start.busy_lo", bsy[0], 1'b0);
    chk("false_start.rda", rda[0], 1'b0);

    align();
    send(0, 9'h0C3, 1'b0, 1'b0, 1'b1);
    gap();
    chk_frame("glitch", 0, 9'h0C3, 0, 0, 0);
    do_ack("glitch", 0);

    k_load = 0;
    align();
    fork
      send(0, 9'h001, 1'b0, 1'b0, 1'b0);
      begin
        bit got = 1'b0;
        while (k_load < 2000 && !got) begin
          @(posedge clk);
          k_load++;
          #1;
          got = rda[0];
        end
      end
    join
    chk("start_to_rda_window", (k_load >= 576 && k_load <= 640), 1'b1);
    if (k_load < 2) k_load = 2;
    gap();
    chk_frame("ovr1", 0, 9'h001, 0, 0, 0);
    align();
    send(0, 9'h002, 1'b0, 1'b0, 1'b0);
    gap();
    chk_frame("ovr2", 0, 9'h002, 0, 0, 1);
    align();
    fork
      send(0, 9'h003, 1'b0, 1'b0, 1'b0);
      begin
        repeat (k_load - 1) @(posedge clk);
        #1 ack[0] = 1'b1;
        @(posedge clk);
        #1 ack[0] = 1'b0;
      end
    join
    gap();
    chk_frame("ack_at_load", 0, 9'h003, 0, 0, 0);

    align();
    fork
      send(0, 9'h0FF, 1'b0, 1'b0, 1'b0);
      begin
        repeat (4 * BIT) @(posedge clk);
        #1 rst_n = 1'b0;
        #20;
        chk("midreset.data", d0, 8'h00);
        chk("midreset.rda", rda[0], 1'b0);
        chk("midreset.errs", {fe[0], pe[0], ov[0]}, 3'b000);
        chk("midreset.busy", bsy[0], 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    gap();
    chk("after_reset.busy", bsy[0], 1'b0);
    chk("after_reset.rda", rda[0], 1'b0);
    align();
    send(0, 9'h081, 1'b0, 1'b0, 1'b0);
    gap();
    chk_frame("post_reset", 0, 9'h081, 0, 0, 0);

    @(negedge clk);
    ack = 3'b111;
    @(negedge clk);
    ack = 3'b000;
    rda_m = '0;
    ov_m  = '0;
    for (int r = 0; r < 24; r++) begin
      int         s;
      logic [8:0] dat;
      bit         pf;
      bit         sb;
      bit         ak;
      s   = $urandom_range(0, 2);
      dat = 9'($urandom) & ((s == 2) ? 9'h1FF : 9'h0FF);
      pf  = (s != 0) && ($urandom_range(0, 3) == 0);
      sb  = ($urandom_range(0, 4) == 0);
      ak  = ($urandom_range(0, 3) != 0);
      align();
      send(s, dat, pf, sb, 1'b0);
      gap();
      ov_m[s]  = ov_m[s] | rda_m[s];
      rda_m[s] = 1'b1;
      chk_frame($sformatf("rand%0d", r), s, dat, sb, pf, ov_m[s]);
      if (ak) begin
        do_ack($sformatf("rand%0d", r), s);
        rda_m[s] = 1'b0;
        ov_m[s]  = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver: the next-generation serial receive path for the minilab SPART/UART datapath. Deserialises an asynchronous RxD line using an oversampling tick from the shared baud rate generator. Supports configurable data width, parity and stop bits, with 3-sample majority voting and false-start rejection. Reports framing, parity and overrun errors, and holds each received byte until the consumer acknowledges it.

## Interface
Parameters:
- DATA_BITS, 8: data bits per frame, legal 5–9; LSB first on the line.
- OVERSAMPLE, 16: baud_tick pulses per bit period; even, legal 8–32.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset; one clock domain only.
- RxD  in  1  serial line, idle high; asynchronous to clk.
- baud_tick  in  1  one-clk pulse, OVERSAMPLE per bit period.
- rd_ack  in  1  consumer has taken rx_data; clears RDA and error flags.
- rx_data  out  DATA_BITS  last received word.
- RDA  out  1  received data available.
- frame_err  out  1  a stop bit sampled 0 in the held frame.
- parity_err  out  1  parity mismatch in the held frame (always 0 when PARITY=0).
- overrun_err  out  1  a new frame was loaded while RDA was still 1.
- busy  out  1  FSM not in IDLE.

## Operation
- RxD passes through a 2-flop synchroniser (preset to 1 on reset); all logic uses the synchronised value rxs.
- Sample counter scnt (log2(OVERSAMPLE) bits) advances only on baud_tick; bit counter bcnt counts data bits.
- Majority vote: rxs is captured at scnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided on the tick at OVERSAMPLE/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: busy=0, scnt held at 0. When rxs=0, go to START.
- START: on the majority decision, a value of 1 is a false start; return to IDLE with no flags changed. A value of 0 continues; scnt wraps at OVERSAMPLE-1 and the FSM enters DATA with bcnt=0.
- DATA: each majority bit shifts in at the MSB (shift right). After DATA_BITS bits, go to PARITY if PARITY≠0, else STOP.
- PARITY: compute expected = XOR(data) for even, ~XOR(data) for odd. Mismatch sets the pending parity flag.
- STOP: each stop bit is voted. A 0 on any stop bit sets the pending frame flag.
- On the final stop-bit decision, in the same clk:
  - load rx_data;
  - set frame_err and parity_err from the pending flags;
  - set RDA=1 and set overrun_err if RDA was already 1;
  - return to IDLE immediately, so the next start edge is caught mid-stop.
- Overrun: new data overwrites rx_data; overrun_err stays set until rd_ack.
- rd_ack with RDA=1 clears RDA, frame_err, parity_err and overrun_err on the next edge. rd_ack with RDA=0 is ignored.
- Simultaneous rd_ack and frame load: the load wins. RDA stays 1, error flags take the new frame's values, and overrun_err=0.
- baud_tick while rxs changes: only sample points matter; glitches outside the voting window are ignored.

## Timing
- Reset (async assert, sync release):
  - FSM=IDLE; scnt, bcnt and the shift register are 0;
  - rx_data=0; RDA, frame_err, parity_err, overrun_err and busy are 0.
- Reset mid-frame aborts the frame with no output change beyond the reset values.
- RxD-to-rxs latency: 2 clk.
- busy rises 1 clk after rxs first reads 0.
- Outputs update 1 clk after the baud_tick that completes the last stop-bit vote. Start-edge to RDA is ≈ (1+DATA_BITS+(PARITY≠0)+STOP_BITS−0.5) bit periods.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- 8N1, OVERSAMPLE=16, baud_tick every 4 clk, send 0xA5 → rx_data=0xA5, RDA=1 and all errors 0. After rd_ack, RDA=0 next clk.
- PARITY=1, send 0x3C with parity bit 1 → parity_err=1 and rx_data=0x3C. Resend with parity 0 → parity_err=0.
- 0x55 sent with stop bit driven 0 → frame_err=1, RDA=1. Line back high then a new frame 0x12 received correctly.
- RxD low pulse of 5 ticks in IDLE → FSM returns to IDLE with RDA=0 and busy=0 afterwards. Also, one sample flipped mid-bit inside the voting window → correct byte.
- Two frames 0x01 then 0x02 without rd_ack → rx_data=0x02, overrun_err=1. Assert rd_ack on the exact load cycle of a third frame 0x03 → RDA=1, overrun_err=0.
- Assert reset mid-DATA of 0xFF → all outputs 0, busy=0. Next frame 0x81 after release received correctly. Also DATA_BITS=9, STOP_BITS=2 with 0x1AB → rx_data=0x1AB.
